hv_bundle_accumulator: RTL and testbench

Per-lane bundling accumulator that consumes the registered 2-bit signed `sel_bit` codes produced by the selector stage. Each encoding cycle's codes are summed into signed saturating counters, one per hypervector lane. When a frame ends, the block emits the majority (sign) bit of every lane as one binarized hypervector word, using a valid/ready handshake. It sits directly downstream of the selector array and upstream of the result store/DMA.

---
 rtl/hv_bundle_accumulator.sv | 145 ++++++++++++++
 tb/tb_hv_bundle_accumulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hv_bundle_accumulator.sv
// Per-lane bundling accumulator: sums selector codes into symmetric saturating counters and
// emits the per-lane majority word per frame. Optional HV_TIE_BREAK_EN: ties resolve to lane parity.

module hv_bundle_lane #(
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
`ifdef HV_TIE_BREAK_EN
    ,
    parameter bit TIE_BIT = 1'b0
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                acc_en,
    input  logic [NUM_IN*2-1:0] codes,
    output logic                maj,
    output logic                clamp
);
    localparam int SW = CNT_W + 2;
    localparam logic signed [SW-1:0] MAXV = {3'b000, {(CNT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = -MAXV;

    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_nxt;
    logic signed [SW-1:0]    sum;

    // Illegal code 2'b10 decodes to 0, same as 2'b00.
    always_comb begin
        sum = {{2{cnt[CNT_W-1]}}, cnt};
        for (int k = 0; k < NUM_IN; k++) begin
            case (codes[k*2 +: 2])
                2'b01:   sum = sum + SW'(1);
                2'b11:   sum = sum - SW'(1);
                default: sum = sum;
            endcase
        end
        clamp   = 1'b0;
        cnt_nxt = sum[CNT_W-1:0];
        if (sum > MAXV) begin
            clamp   = 1'b1;
            cnt_nxt = MAXV[CNT_W-1:0];
        end else if (sum < MINV) begin
            clamp   = 1'b1;
            cnt_nxt = MINV[CNT_W-1:0];
        end
    end

`ifdef HV_TIE_BREAK_EN
    assign maj = (cnt_nxt == '0) ? TIE_BIT : cnt_nxt[CNT_W-1];
`else
    assign maj = cnt_nxt[CNT_W-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clr)    cnt <= '0;
        else if (acc_en) cnt <= cnt_nxt;
    end
endmodule

module hv_bundle_accumulator #(
    parameter int LANES  = 32,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [LANES*NUM_IN*2-1:0] sel_in,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_bits,
    output logic                      busy,
    output logic                      sat_flag
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

    state_t                             state;
    logic [LANES-1:0][NUM_IN*2-1:0]     sel_lane;
    logic [LANES-1:0]                   maj;
    logic [LANES-1:0]                   clamp;
    logic                               acc_en;

    assign sel_lane = sel_in;
    // A beat coinciding with start is dropped: start only clears.
    assign acc_en   = (state == S_ACCUM) && in_valid && !start;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        hv_bundle_lane #(
            .NUM_IN (NUM_IN),
            .CNT_W  (CNT_W)
`ifdef HV_TIE_BREAK_EN
            ,
            .TIE_BIT(l[0])
`endif
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start),
            .acc_en(acc_en),
            .codes (sel_lane[l]),
            .maj   (maj[l]),
            .clamp (clamp[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_bits  <= '0;
            busy      <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (start) begin
            state     <= S_ACCUM;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (in_valid) begin
                        if (|clamp) sat_flag <= 1'b1;
                        if (in_last) begin
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                            out_bits  <= maj;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hv_bundle_accumulator.sv
// Scoreboard bench for hv_bundle_accumulator: stimulus pushes expected words, monitor pops on transfer.

module tb_hv_bundle_accumulator;
    localparam int LANES  = 32;
    localparam int NUM_IN = 2;
    localparam int SW     = LANES * NUM_IN * 2;
`ifdef HV_TIE_BREAK_EN
    localparam logic [31:0] TIE = 32'hAAAAAAAA;
`else
    localparam logic [31:0] TIE = 32'h00000000;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            in_valid;
    logic [SW-1:0]   sel_in;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [LANES-1:0] out_bits;
    logic            busy;
    logic            sat_flag;

    typedef struct {
        logic [31:0] bits;
        logic        sat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    hv_bundle_accumulator #(.LANES(LANES), .NUM_IN(NUM_IN), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .sel_in   (sel_in),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits (out_bits),
        .busy     (busy),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when valid & ready are seen here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h with empty scoreboard", out_bits);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("word_bits", out_bits, e.bits);
                chk("word_sat", {31'b0, sat_flag}, {31'b0, e.sat});
            end
        end
    end

    function automatic logic [SW-1:0] fill(input logic [1:0] c);
        logic [SW-1:0] r;
        for (int i = 0; i < SW/2; i++) r[i*2 +: 2] = c;
        return r;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic beat(input logic [SW-1:0] s, input logic last);
        in_valid = 1'b1;
        sel_in   = s;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk); #1;
            if (!out_valid) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: out_valid still 1 expected 0");
        end
    endtask

    initial begin
        logic [SW-1:0] t2;
        for (int l = 0; l < LANES; l++) t2[l*4 +: 4] = (l == 0) ? 4'hF : 4'hD;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        sel_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_bits", out_bits, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_sat", {31'b0, sat_flag}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All +1: counters reach +6.
        do_start();
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        q.push_back('{bits: 32'h0, sat: 1'b0});
        beat(fill(2'b01), 1'b0);
        beat(fill(2'b01), 1'b0);
        beat(fill(2'b01), 1'b1);
        chk("latency_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("post_xfer_valid", {31'b0, out_valid}, 32'd0);
        chk("post_xfer_busy", {31'b0, busy}, 32'd0);

        // Lane 0 negative, other lanes tie.
        do_start();
        q.push_back('{bits: TIE | 32'h1, sat: 1'b0});
        beat(t2, 1'b0);
        beat(t2, 1'b1);
        drain();

        // Saturation at +127 over 70 beats.
        do_start();
        q.push_back('{bits: 32'h0, sat: 1'b1});
        for (int i = 0; i < 70; i++) beat(fill(2'b01), i == 69);
        drain();
        do_start();
        chk("sat_cleared_by_start", {31'b0, sat_flag}, 32'd0);

        // Illegal code contributes nothing.
        q.push_back('{bits: TIE, sat: 1'b0});
        for (int i = 0; i < 4; i++) beat(fill(2'b10), i == 3);
        drain();

        // Backpressure: word stable, in_valid ignored in OUT.
        do_start();
        out_ready = 1'b0;
        beat(fill(2'b11), 1'b1);
        chk("bp_valid_first", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b1; in_last = 1'b1; sel_in = fill(2'b01);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", {31'b0, out_valid}, 32'd1);
            chk("bp_bits_hold", out_bits, 32'hFFFFFFFF);
            chk("bp_sat_hold", {31'b0, sat_flag}, 32'd0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        q.push_back('{bits: 32'hFFFFFFFF, sat: 1'b0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_busy", {31'b0, busy}, 32'd0);

        // start in OUT drops the word; beat with start is not accumulated.
        do_start();
        out_ready = 1'b0;
        beat(fill(2'b11), 1'b1);
        chk("drop_valid_before", {31'b0, out_valid}, 32'd1);
        start = 1'b1; in_valid = 1'b1; sel_in = fill(2'b01);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        chk("drop_valid_after", {31'b0, out_valid}, 32'd0);
        chk("drop_busy_after", {31'b0, busy}, 32'd1);
        out_ready = 1'b1;
        q.push_back('{bits: TIE, sat: 1'b0});
        beat(fill(2'b00), 1'b1);
        drain();

        // Asynchronous reset mid-ACCUM with a stale nonzero out_bits.
        do_start();
        out_ready = 1'b0;
        beat(fill(2'b11), 1'b1);
        do_start();
        beat(fill(2'b01), 1'b0);
        chk("pre_rst_bits", out_bits, 32'hFFFFFFFF);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_out_bits", out_bits, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_sat", {31'b0, sat_flag}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
